// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker cpu I/O bridge.
package tinker_pkg;

  typedef logic [63:0] word_t;

  localparam int unsigned IO_FIFO_DEPTH = 8;

endpackage

// File: rtl/tinker_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module tinker_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned DataW = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DataW-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [DataW-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam logic [Aw:0] PtrOne = {{Aw{1'b0}}, 1'b1};

  logic [DataW-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // No valid head when empty, so a pop there is ignored; the push still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero when empty so consumers never see stale storage.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[Aw-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q[Aw-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/tinker_io_bridge.sv
// Buffers cpu I/O port traffic: edge-detected cpu strobes feed FIFOs toward and from a host
// valid/ready stream, with sticky overflow/underflow flags.
module tinker_io_bridge
  import tinker_pkg::*;
#(
  parameter int unsigned DEPTH  = IO_FIFO_DEPTH,
  parameter int unsigned DATA_W = $bits(word_t)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_out_signal,
  input  logic [DATA_W-1:0]        cpu_out_data,
  input  logic                     cpu_in_signal,
  output logic [DATA_W-1:0]        cpu_in_data,
  output logic                     host_out_valid,
  output logic [DATA_W-1:0]        host_out_data,
  input  logic                     host_out_ready,
  input  logic                     host_in_valid,
  input  logic [DATA_W-1:0]        host_in_data,
  output logic                     host_in_ready,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic                     overflow,
  output logic                     underflow
);

  logic prev_out_q, prev_out_d;
  logic prev_in_q, prev_in_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic out_push, out_pop, out_full, out_empty;
  logic in_push, in_pop, in_full, in_empty;

  // cpu strobes are levels; only the rising edge is an event.
  assign out_push = cpu_out_signal & ~prev_out_q;
  assign in_pop   = cpu_in_signal & ~prev_in_q;

  assign host_out_valid = ~out_empty;
  assign out_pop        = host_out_valid & host_out_ready;
  assign host_in_ready  = ~in_full;
  assign in_push        = host_in_valid & host_in_ready;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    // Edge registers track the level even in reset so a held strobe is not an event later.
    prev_out_d  = cpu_out_signal;
    prev_in_d   = cpu_in_signal;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (reset) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (out_push && out_full && !out_pop) overflow_d  = 1'b1;
      if (in_pop && in_empty)               underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    prev_out_q  <= prev_out_d;
    prev_in_q   <= prev_in_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  tinker_fifo #(
    .Depth (DEPTH),
    .DataW (DATA_W)
  ) u_out_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (out_push),
    .push_data_i (cpu_out_data),
    .pop_i       (out_pop),
    .head_o      (host_out_data),
    .full_o      (out_full),
    .empty_o     (out_empty),
    .count_o     (out_count)
  );

  tinker_fifo #(
    .Depth (DEPTH),
    .DataW (DATA_W)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_push),
    .push_data_i (host_in_data),
    .pop_i       (in_pop),
    .head_o      (cpu_in_data),
    .full_o      (in_full),
    .empty_o     (in_empty),
    .count_o     (in_count)
  );

endmodule

// File: tb/tb_tinker_io_bridge.sv
// Directed self-checking bench for tinker_io_bridge (DEPTH 8, 64-bit words).
module tb_tinker_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_out_signal;
  logic [63:0] cpu_out_data;
  logic        cpu_in_signal;
  logic [63:0] cpu_in_data;
  logic        host_out_valid;
  logic [63:0] host_out_data;
  logic        host_out_ready;
  logic        host_in_valid;
  logic [63:0] host_in_data;
  logic        host_in_ready;
  logic [3:0]  out_count;
  logic [3:0]  in_count;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tinker_io_bridge #(
    .DEPTH  (8),
    .DATA_W (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_out_signal (cpu_out_signal),
    .cpu_out_data   (cpu_out_data),
    .cpu_in_signal  (cpu_in_signal),
    .cpu_in_data    (cpu_in_data),
    .host_out_valid (host_out_valid),
    .host_out_data  (host_out_data),
    .host_out_ready (host_out_ready),
    .host_in_valid  (host_in_valid),
    .host_in_data   (host_in_data),
    .host_in_ready  (host_in_ready),
    .out_count      (out_count),
    .in_count       (in_count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_out(input logic [63:0] w);
    cpu_out_data   = w;
    cpu_out_signal = 1'b1;
    tick();
    cpu_out_signal = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    cpu_out_signal = 0; cpu_out_data = 0; cpu_in_signal = 0;
    host_out_ready = 0; host_in_valid = 0; host_in_data = 0;
    apply_reset();
    checks++; if (out_count !== 4'd0) begin errors++;
      $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (in_count !== 4'd0) begin errors++;
      $display("FAIL reset_in_count got=%0d exp=0", in_count); end
    checks++; if (host_out_valid !== 1'b0 || host_in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_handshake got valid=%b ready=%b exp valid=0 ready=1",
               host_out_valid, host_in_ready); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++;
      $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", overflow, underflow); end
    checks++; if (cpu_in_data !== 64'd0) begin errors++;
      $display("FAIL reset_cpu_in_data got=%h exp=0", cpu_in_data); end
  endtask

  task automatic test_out_pulse();
    host_out_ready = 1'b1;
    cpu_out_data   = 64'h2A;
    cpu_out_signal = 1'b1;
    tick();
    checks++; if (host_out_valid !== 1'b1 || host_out_data !== 64'h2A || out_count !== 4'd1)
    begin errors++;
      $display("FAIL pulse_present got valid=%b data=%h cnt=%0d exp 1 2a 1",
               host_out_valid, host_out_data, out_count); end
    cpu_out_signal = 1'b0;
    tick();
    checks++; if (host_out_valid !== 1'b0 || out_count !== 4'd0) begin errors++;
      $display("FAIL pulse_drained got valid=%b cnt=%0d exp 0 0", host_out_valid, out_count); end
    host_out_ready = 1'b0;
  endtask

  task automatic test_level_hold();
    cpu_out_data   = 64'd7;
    cpu_out_signal = 1'b1;
    repeat (5) tick();
    checks++; if (out_count !== 4'd1 || host_out_data !== 64'd7) begin errors++;
      $display("FAIL level_hold got cnt=%0d data=%h exp 1 7", out_count, host_out_data); end
    cpu_out_signal = 1'b0;
    host_out_ready = 1'b1;
    tick();
    host_out_ready = 1'b0;
    checks++; if (out_count !== 4'd0) begin errors++;
      $display("FAIL level_hold_drain got cnt=%0d exp 0", out_count); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] exp_q [8];
    apply_reset();
    for (int i = 0; i < 8; i++) push_out(64'h100 + 64'(i));
    checks++; if (out_count !== 4'd8) begin errors++;
      $display("FAIL fpp_fill got cnt=%0d exp 8", out_count); end
    cpu_out_data   = 64'h1FF;
    cpu_out_signal = 1'b1;
    host_out_ready = 1'b1;
    tick();
    cpu_out_signal = 1'b0;
    checks++; if (out_count !== 4'd8 || overflow !== 1'b0) begin errors++;
      $display("FAIL fpp_count got cnt=%0d ovf=%b exp 8 0", out_count, overflow); end
    for (int i = 0; i < 7; i++) exp_q[i] = 64'h101 + 64'(i);
    exp_q[7] = 64'h1FF;
    for (int i = 0; i < 8; i++) begin
      checks++; if (host_out_valid !== 1'b1 || host_out_data !== exp_q[i]) begin errors++;
        $display("FAIL fpp_order[%0d] got valid=%b data=%h exp 1 %h",
                 i, host_out_valid, host_out_data, exp_q[i]); end
      tick();
    end
    host_out_ready = 1'b0;
    checks++; if (out_count !== 4'd0 || host_out_valid !== 1'b0) begin errors++;
      $display("FAIL fpp_empty got cnt=%0d valid=%b exp 0 0", out_count, host_out_valid); end
  endtask

  task automatic test_overflow();
    host_out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push_out(64'(i));
    checks++; if (out_count !== 4'd8 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_state got cnt=%0d ovf=%b exp 8 1", out_count, overflow); end
    host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (host_out_valid !== 1'b1 || host_out_data !== 64'(i)) begin errors++;
        $display("FAIL ovf_drain[%0d] got valid=%b data=%h exp 1 %h",
                 i, host_out_valid, host_out_data, 64'(i)); end
      tick();
    end
    host_out_ready = 1'b0;
    checks++; if (out_count !== 4'd0 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky got cnt=%0d ovf=%b exp 0 1", out_count, overflow); end
  endtask

  task automatic test_input();
    host_in_valid = 1'b1;
    host_in_data  = 64'h10;
    tick();
    checks++; if (cpu_in_data !== 64'h10) begin errors++;
      $display("FAIL in_first_latency got=%h exp=10", cpu_in_data); end
    host_in_data  = 64'h20;
    tick();
    host_in_valid = 1'b0;
    checks++; if (in_count !== 4'd2 || cpu_in_data !== 64'h10) begin errors++;
      $display("FAIL in_loaded got cnt=%0d data=%h exp 2 10", in_count, cpu_in_data); end
    cpu_in_signal = 1'b1;
    tick();
    checks++; if (in_count !== 4'd1 || cpu_in_data !== 64'h20) begin errors++;
      $display("FAIL in_pop1 got cnt=%0d data=%h exp 1 20", in_count, cpu_in_data); end
    tick();
    checks++; if (in_count !== 4'd1) begin errors++;
      $display("FAIL in_level_no_pop got cnt=%0d exp 1", in_count); end
    cpu_in_signal = 1'b0; tick();
    cpu_in_signal = 1'b1; tick();
    checks++; if (in_count !== 4'd0 || cpu_in_data !== 64'd0 || underflow !== 1'b0) begin errors++;
      $display("FAIL in_pop2 got cnt=%0d data=%h unf=%b exp 0 0 0",
               in_count, cpu_in_data, underflow); end
    cpu_in_signal = 1'b0; tick();
    cpu_in_signal = 1'b1; tick();
    cpu_in_signal = 1'b0;
    checks++; if (underflow !== 1'b1 || in_count !== 4'd0) begin errors++;
      $display("FAIL in_underflow got unf=%b cnt=%0d exp 1 0", underflow, in_count); end
  endtask

  task automatic test_reset_mid();
    host_out_ready = 1'b0;
    push_out(64'h31);
    push_out(64'h32);
    cpu_out_data   = 64'h33;
    cpu_out_signal = 1'b1;
    host_in_valid  = 1'b1;
    host_in_data   = 64'h44;
    tick();
    host_in_valid  = 1'b0;
    checks++; if (out_count !== 4'd3 || in_count !== 4'd1) begin errors++;
      $display("FAIL mid_loaded got out=%0d in=%0d exp 3 1", out_count, in_count); end
    cpu_out_data = 64'h55;
    apply_reset();
    tick();
    checks++; if (out_count !== 4'd0 || in_count !== 4'd0 || host_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared got out=%0d in=%0d valid=%b exp 0 0 0",
               out_count, in_count, host_out_valid); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || cpu_in_data !== 64'd0) begin
      errors++;
      $display("FAIL mid_flags got ovf=%b unf=%b data=%h exp 0 0 0",
               overflow, underflow, cpu_in_data); end
    cpu_out_signal = 1'b0;
    tick();
    checks++; if (out_count !== 4'd0) begin errors++;
      $display("FAIL mid_no_push got cnt=%0d exp 0", out_count); end
  endtask

  initial begin
    test_reset();
    test_out_pulse();
    test_level_hold();
    test_full_push_pop();
    test_overflow();
    test_input();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
